// File: rtl/aes128_type_pkg.sv
// Shared types and constants for the AES MixColumns sequencer and its
// iterative GF(2^8) multiplier.
//   - mix_state_e   : sequencer FSM states
//   - gmul_state_e  : multiplier FSM states
//   - MIX_*_COEF    : first matrix row (base) for forward / inverse transform
//   - mix_coef()    : base[k] lookup for either direction
//   - gf_xtime()    : multiply-by-x in GF(2^8) modulo x^8+x^4+x^3+x+1
package aes128_type_pkg;

    typedef enum logic [1:0] {
        MixIdle,
        MixTerm,
        MixMulWait,
        MixDone
    } mix_state_e;

    typedef enum logic [1:0] {
        GmWait,
        GmAdd,
        GmXtime,
        GmDone
    } gmul_state_e;

    // Element [3] is base[0]; the concatenation lists base[0] first.
    localparam logic [3:0][7:0] MIX_FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [3:0][7:0] MIX_INV_COEF = {8'h0E, 8'h0B, 8'h0D, 8'h09};

    // base[k]; for a 2-bit k, element 3-k is simply ~k.
    function automatic logic [7:0] mix_coef(input logic inv, input logic [1:0] k);
        mix_coef = inv ? MIX_INV_COEF[~k] : MIX_FWD_COEF[~k];
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        gf_xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_mixcol_seq_if.sv
// Request/response bundle between the round controller and the MixColumns
// sequencer.
//   start_i : begin one column (sampled only while the sequencer is idle)
//   inv_i   : 0 = MixColumns, 1 = InvMixColumns
//   col_i   : input column, byte r at [8r+7:8r]
//   busy_o  : sequencer not idle
//   col_o   : result column, same byte order, held until the next result
//   valid_o : one-cycle pulse when col_o is updated
interface aes128_mixcol_seq_if;
    logic        start_i;
    logic        inv_i;
    logic [31:0] col_i;
    logic        busy_o;
    logic [31:0] col_o;
    logic        valid_o;

    modport master (
        output start_i, inv_i, col_i,
        input  busy_o, col_o, valid_o
    );

    modport slave (
        input  start_i, inv_i, col_i,
        output busy_o, col_o, valid_o
    );
endinterface

// File: rtl/aes128_gmul.sv
// Iterative GF(2^8) multiplier for small coefficients (a_i <= 15).
// Walks a_i LSB-first: one cycle to conditionally add the shifted operand,
// one cycle to xtime it, stopping at the most significant set bit of a_i.
// Latency from start cycle to valid cycle is 2*(msb(a_i)+1).
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   start_i  : begin a product (sampled in WAIT)
//   a_i      : coefficient, re-read every step, must stay stable
//   b_i      : data byte, captured at start
//   result_o : product, valid while valid_o is high
//   valid_o  : one-cycle completion pulse
module aes128_gmul
    import aes128_type_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] result_o,
    output logic       valid_o
);

    gmul_state_e state_q;
    logic [7:0]  b_q;
    logic [7:0]  p_q;
    logic [1:0]  idx_q;
    logic [1:0]  msb;
    logic [7:0]  p_add;

    always_comb begin
        msb = 2'd0;
        if (a_i[3]) begin
            msb = 2'd3;
        end else if (a_i[2]) begin
            msb = 2'd2;
        end else if (a_i[1]) begin
            msb = 2'd1;
        end
        p_add = p_q ^ (a_i[idx_q] ? b_q : 8'h00);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= GmWait;
            b_q     <= 8'h00;
            p_q     <= 8'h00;
            idx_q   <= 2'd0;
        end else begin
            unique case (state_q)
                GmWait: begin
                    if (start_i) begin
                        b_q     <= b_i;
                        p_q     <= 8'h00;
                        idx_q   <= 2'd0;
                        state_q <= GmAdd;
                    end
                end
                GmAdd: begin
                    p_q     <= p_add;
                    // No shift after the last bit: go straight to DONE.
                    state_q <= (idx_q == msb) ? GmDone : GmXtime;
                end
                GmXtime: begin
                    b_q     <= gf_xtime(b_q);
                    idx_q   <= idx_q + 2'd1;
                    state_q <= GmAdd;
                end
                GmDone: begin
                    state_q <= GmWait;
                end
            endcase
        end
    end

    assign result_o = p_q;
    assign valid_o  = (state_q == GmDone);

endmodule

// File: rtl/aes128_mixcol_seq.sv
// AES (Inv)MixColumns for one 32-bit column using a single time-shared
// iterative multiplier. Rows 0..3 are produced in order; within a row the
// four terms M[r][j]*s_j are XOR-accumulated, coefficient 01 terms bypass
// the multiplier. The finished column is presented with a one-cycle valid.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : request/response bundle (slave side)
module aes128_mixcol_seq
    import aes128_type_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    aes128_mixcol_seq_if.slave         bus
);

    mix_state_e      state_q;
    logic [1:0]      row_cnt_q;
    logic [1:0]      term_cnt_q;
    logic [7:0]      acc_q;
    logic [3:0][7:0] res_q;
    logic [3:0][7:0] col_q;
    logic            inv_q;
    logic [31:0]     col_o_q;

    logic [1:0]      coef_idx;
    logic [7:0]      coef;
    logic [7:0]      s_term;
    logic            bypass;
    logic            gmul_start;
    logic [7:0]      gmul_result;
    logic            gmul_valid;
    logic            fold_en;
    logic [7:0]      row_val;
    logic [3:0][7:0] res_done;

    always_comb begin
        coef_idx   = term_cnt_q - row_cnt_q;  // (j - r) mod 4
        coef       = mix_coef(inv_q, coef_idx);
        s_term     = col_q[term_cnt_q];
        bypass     = (coef == 8'h01);
        gmul_start = (state_q == MixTerm) && !bypass;
        fold_en    = ((state_q == MixTerm) && bypass) ||
                     ((state_q == MixMulWait) && gmul_valid);
        row_val    = acc_q ^ ((state_q == MixTerm) ? s_term : gmul_result);
        res_done            = res_q;
        res_done[row_cnt_q] = row_val;
    end

    // Operands come straight from the held counters, so they stay stable
    // from the issuing TERM cycle until the product is folded in.
    aes128_gmul u_gmul (
        .clk_i    (clk_i),
        .rst_ni   (~rst_i),
        .start_i  (gmul_start),
        .a_i      (coef[3:0]),
        .b_i      (s_term),
        .result_o (gmul_result),
        .valid_o  (gmul_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= MixIdle;
            row_cnt_q  <= 2'd0;
            term_cnt_q <= 2'd0;
            acc_q      <= 8'h00;
            res_q      <= '0;
            col_q      <= '0;
            inv_q      <= 1'b0;
            col_o_q    <= 32'h0;
        end else begin
            unique case (state_q)
                MixIdle: begin
                    if (bus.start_i) begin
                        col_q      <= bus.col_i;
                        inv_q      <= bus.inv_i;
                        row_cnt_q  <= 2'd0;
                        term_cnt_q <= 2'd0;
                        acc_q      <= 8'h00;
                        res_q      <= '0;
                        state_q    <= MixTerm;
                    end
                end
                MixTerm, MixMulWait: begin
                    if (fold_en) begin
                        if (term_cnt_q == 2'd3) begin
                            res_q      <= res_done;
                            acc_q      <= 8'h00;
                            term_cnt_q <= 2'd0;
                            if (row_cnt_q == 2'd3) begin
                                // Load the output here so col_o is already
                                // valid in the DONE cycle.
                                col_o_q <= res_done;
                                state_q <= MixDone;
                            end else begin
                                row_cnt_q <= row_cnt_q + 2'd1;
                                state_q   <= MixTerm;
                            end
                        end else begin
                            acc_q      <= row_val;
                            term_cnt_q <= term_cnt_q + 2'd1;
                            state_q    <= MixTerm;
                        end
                    end else if (state_q == MixTerm) begin
                        state_q <= MixMulWait;
                    end
                end
                MixDone: begin
                    state_q <= MixIdle;
                end
            endcase
        end
    end

    assign bus.busy_o  = (state_q != MixIdle);
    assign bus.valid_o = (state_q == MixDone);
    assign bus.col_o   = col_o_q;

endmodule

// File: tb/tb_aes128_mixcol_seq.sv
module tb_aes128_mixcol_seq;

    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Multiplier-side monitor counters (written only by the monitor).
    int          mon_starts = 0;
    int          mon_viol   = 0;
    int          mon_valid  = 0;
    logic        g_busy     = 1'b0;
    logic [3:0]  g_a;
    logic [7:0]  g_b;

    aes128_mixcol_seq_if bus ();

    aes128_mixcol_seq dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            g_busy = 1'b0;
        end else begin
            if (bus.valid_o) mon_valid++;
            if (g_busy) begin
                if (dut.u_gmul.a_i !== g_a || dut.u_gmul.b_i !== g_b) mon_viol++;
                if (dut.u_gmul.valid_o) g_busy = 1'b0;
            end else if (dut.u_gmul.start_i) begin
                g_a = dut.u_gmul.a_i;
                g_b = dut.u_gmul.b_i;
                mon_starts++;
                g_busy = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start one column in the current cycle (cycle 0), scramble col_i while
    // busy, and check result, timing, pulse count and multiplier usage.
    task automatic run_col(input string tag, input logic inv, input logic [31:0] col,
                           input logic [31:0] exp_col, input int exp_cyc,
                           input int exp_starts);
        int          valid_at;
        int          nv;
        int          s0;
        int          v0;
        logic        busy1;
        logic        busy_done;
        logic [31:0] got;
        valid_at  = -1;
        nv        = 0;
        busy1     = 1'b0;
        busy_done = 1'b0;
        got       = 32'hx;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.inv_i   = inv;
        bus.col_i   = col;
        s0 = mon_starts;
        v0 = mon_viol;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start_i = 1'b0;
                bus.col_i   = ~col;
                bus.inv_i   = ~inv;
                busy1       = bus.busy_o;
            end
            if (bus.valid_o) begin
                nv++;
                if (valid_at < 0) begin
                    valid_at  = c;
                    got       = bus.col_o;
                    busy_done = bus.busy_o;
                end
            end
            if (valid_at >= 0 && c >= valid_at + 3) break;
        end
        check({tag, " valid cycle"}, valid_at, exp_cyc);
        check({tag, " col_o"}, got, exp_col);
        check({tag, " pulse count"}, nv, 1);
        check({tag, " busy cycle1"}, {31'd0, busy1}, 32'd1);
        check({tag, " busy in done"}, {31'd0, busy_done}, 32'd1);
        check({tag, " busy after"}, {31'd0, bus.busy_o}, 32'd0);
        check({tag, " col_o held"}, bus.col_o, exp_col);
        check({tag, " gmul starts"}, mon_starts - s0, exp_starts);
        check({tag, " gmul operands"}, mon_viol - v0, 0);
    endtask

    initial begin
        int          v1_at;
        int          v2_at;
        int          nv;
        int          vsnap;
        logic [31:0] v1_col;
        logic [31:0] v2_col;

        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.inv_i   = 1'b0;
        bus.col_i   = 32'h0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, bus.busy_o}, 32'd0);
        check("reset valid", {31'd0, bus.valid_o}, 32'd0);
        check("reset col_o", bus.col_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_col("fwd db134553", 1'b0, 32'h455313DB, 32'hBCA14D8E, 49, 8);
        run_col("inv 8e4da1bc", 1'b1, 32'hBCA14D8E, 32'h455313DB, 145, 16);
        run_col("fwd f20a225c", 1'b0, 32'h5C220AF2, 32'h9D58DC9F, 49, 8);
        run_col("fwd 01s", 1'b0, 32'h01010101, 32'h01010101, 49, 8);
        run_col("inv 01s", 1'b1, 32'h01010101, 32'h01010101, 145, 16);
        run_col("fwd c6s", 1'b0, 32'hC6C6C6C6, 32'hC6C6C6C6, 49, 8);
        run_col("inv c6s", 1'b1, 32'hC6C6C6C6, 32'hC6C6C6C6, 145, 16);
        run_col("fwd zero", 1'b0, 32'h00000000, 32'h00000000, 49, 8);

        // start_i held high: one result at 49, restart at 50, next at 99.
        // col_i changes mid-operation and is only picked up by the restart.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.inv_i   = 1'b0;
        bus.col_i   = 32'h455313DB;
        v1_at = -1;
        v2_at = -1;
        v1_col = 32'hx;
        v2_col = 32'hx;
        nv = 0;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            if (c == 10) bus.col_i = 32'h5C220AF2;
            if (c == 60) bus.start_i = 1'b0;
            if (bus.valid_o) begin
                nv++;
                if (v1_at < 0) begin
                    v1_at  = c;
                    v1_col = bus.col_o;
                end else if (v2_at < 0) begin
                    v2_at  = c;
                    v2_col = bus.col_o;
                end
            end
        end
        check("held first cycle", v1_at, 49);
        check("held first col", v1_col, 32'hBCA14D8E);
        check("held second cycle", v2_at, 99);
        check("held second col", v2_col, 32'h9D58DC9F);
        check("held pulse count", nv, 2);

        // Reset at cycle 20 of an inverse operation.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.inv_i   = 1'b1;
        bus.col_i   = 32'hBCA14D8E;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
        end
        check("pre-reset busy", {31'd0, bus.busy_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", {31'd0, bus.busy_o}, 32'd0);
        check("midrst col_o", bus.col_o, 32'h0);
        check("midrst valid", {31'd0, bus.valid_o}, 32'd0);
        vsnap = mon_valid;
        repeat (150) @(negedge clk);
        check("midrst no valid", mon_valid - vsnap, 0);
        check("midrst col_o kept", bus.col_o, 32'h0);
        run_col("post-reset fwd", 1'b0, 32'h455313DB, 32'hBCA14D8E, 49, 8);

        // Reset and start in the same cycle: the start is dropped.
        @(negedge clk);
        rst         = 1'b1;
        bus.start_i = 1'b1;
        bus.inv_i   = 1'b0;
        bus.col_i   = 32'h455313DB;
        @(negedge clk);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        check("rst+start busy", {31'd0, bus.busy_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
